// File: rtl/disp_scroll_amisha.sv
// Scrolling message engine for a 4-digit 7-segment display: buffers up to DEPTH
// patterns and shifts them right-to-left one digit per DVSR clocks. Define SCROLL_LOOP_EN to repeat passes until stopped.
module disp_scroll_amisha #(
  parameter int DVSR  = 50000000,
  parameter int DEPTH = 8
) (
  input  logic       clk_amisha,
  input  logic       reset_amisha,
  input  logic       wr_en_amisha,
  input  logic [7:0] wr_data_amisha,
  input  logic       clr_amisha,
  input  logic       start_amisha,
  input  logic       stop_amisha,
  output logic       wr_ready_amisha,
  output logic       busy_amisha,
  output logic       done_amisha,
  output logic [7:0] in3_amisha,
  output logic [7:0] in2_amisha,
  output logic [7:0] in1_amisha,
  output logic [7:0] in0_amisha
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // Pointer/length width covers the len+4 shifts of a full pass.
  localparam int PW = $clog2(DEPTH + 5);
  localparam int CW = $clog2(DVSR);

  typedef enum logic {IDLE, SCROLL} state_t;

  state_t        state_q;
  logic [PW-1:0] len_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic          wr_ready_q;
  logic          busy_q;
  logic          done_q;
  logic [7:0]    dig_q [4];
  logic [7:0]    mem [DEPTH];

  logic          is_idle;
  logic          wr_acc;
  logic [PW-1:0] len_d;
  logic          start_acc;
  logic          tick;
  logic          last_shift;
  logic [7:0]    rd_byte;

  assign is_idle    = (state_q == IDLE);
  assign wr_acc     = is_idle && wr_en_amisha && !clr_amisha && (len_q < PW'(DEPTH));
  assign len_d      = (is_idle && clr_amisha) ? '0 :
                      wr_acc ? len_q + PW'(1) : len_q;
  assign start_acc  = is_idle && start_amisha && (len_d != '0);
  assign tick       = (state_q == SCROLL) && (cnt_q == CW'(DVSR - 1));
  assign last_shift = tick && (rd_ptr_q == len_q + PW'(3));
  assign rd_byte    = (rd_ptr_q < len_q) ? mem[rd_ptr_q[AW-1:0]] : 8'hFF;

  // Message storage carries no reset so it can map onto plain RAM.
  always_ff @(posedge clk_amisha) begin
    if (wr_acc) mem[len_q[AW-1:0]] <= wr_data_amisha;
  end

  always_ff @(posedge clk_amisha or posedge reset_amisha) begin
    if (reset_amisha) begin
      state_q    <= IDLE;
      len_q      <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      wr_ready_q <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < 4; i++) dig_q[i] <= 8'hFF;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          len_q <= len_d;
          if (start_acc) begin
            state_q    <= SCROLL;
            cnt_q      <= '0;
            rd_ptr_q   <= '0;
            busy_q     <= 1'b1;
            wr_ready_q <= 1'b0;
            for (int i = 0; i < 4; i++) dig_q[i] <= 8'hFF;
          end else begin
            wr_ready_q <= (len_d < PW'(DEPTH));
          end
        end
        SCROLL: begin
          if (stop_amisha) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rd_ptr_q   <= '0;
            busy_q     <= 1'b0;
            wr_ready_q <= (len_q < PW'(DEPTH));
            for (int i = 0; i < 4; i++) dig_q[i] <= 8'hFF;
          end else if (tick) begin
            cnt_q <= '0;
            if (last_shift) begin
              done_q   <= 1'b1;
              rd_ptr_q <= '0;
              for (int i = 0; i < 4; i++) dig_q[i] <= 8'hFF;
`ifdef SCROLL_LOOP_EN
              state_q  <= SCROLL;
`else
              state_q    <= IDLE;
              busy_q     <= 1'b0;
              wr_ready_q <= (len_q < PW'(DEPTH));
`endif
            end else begin
              // dig_q[3] is the leftmost digit; new data enters on the right.
              dig_q[3] <= dig_q[2];
              dig_q[2] <= dig_q[1];
              dig_q[1] <= dig_q[0];
              dig_q[0] <= rd_byte;
              rd_ptr_q <= rd_ptr_q + PW'(1);
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wr_ready_amisha = wr_ready_q;
  assign busy_amisha     = busy_q;
  assign done_amisha     = done_q;
  assign in3_amisha      = dig_q[3];
  assign in2_amisha      = dig_q[2];
  assign in1_amisha      = dig_q[1];
  assign in0_amisha      = dig_q[0];

endmodule

// File: doc/disp_scroll_amisha.md
DISP_SCROLL_AMISHA -- requirements
Module: disp_scroll_amisha

Interface
REQ-001 SHALL have parameter DVSR, default 50000000, meaning clocks per scroll step (>=2).
REQ-002 SHALL have parameter DEPTH, default 8, meaning message buffer entries (power of 2).
REQ-003 SHALL have port clk_amisha, input, 1, the single clock; all state on rising edge.
REQ-004 SHALL have port reset_amisha, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port wr_en_amisha, input, 1, write strobe for one segment-pattern byte.
REQ-006 SHALL have port wr_data_amisha, input, 8, segment pattern, active-low, bit 7 = dp.
REQ-007 SHALL have port clr_amisha, input, 1, empties message buffer (IDLE only).
REQ-008 SHALL have port start_amisha, input, 1, begin scroll pass.
REQ-009 SHALL have port stop_amisha, input, 1, abort scroll.
REQ-010 SHALL have port wr_ready_amisha, output, 1, write will be accepted this cycle.
REQ-011 SHALL have port busy_amisha, output, 1, high while scrolling.
REQ-012 SHALL have port done_amisha, output, 1, one-cycle pulse at end of pass.
REQ-013 SHALL have ports in3_amisha..in0_amisha, output, 8 each, digit patterns to the 4-digit display mux; in3 leftmost.

Function
REQ-014 SHALL implement FSM states IDLE and SCROLL; all outputs registered.
REQ-015 IDLE: wr_ready_amisha = (len < DEPTH); accepted write stores byte at index len, len increments.
REQ-016 Write when full or in SCROLL SHALL be ignored; wr_ready_amisha low in SCROLL.
REQ-017 clr_amisha in IDLE SHALL set len to 0; clr with wr_en same cycle: clr wins, write dropped.
REQ-018 start_amisha in IDLE SHALL enter SCROLL if length including a same-cycle write is >0; else ignored.
REQ-019 Entering SCROLL SHALL clear tick counter and read pointer, set busy_amisha, blank all digits (8'hFF).
REQ-020 Tick SHALL occur when counter = DVSR-1, then counter wraps to 0; first tick DVSR clocks after start accepted.
REQ-021 Each tick SHALL shift left: in3<=in2, in2<=in1, in1<=in0, in0<=buffer[rd_ptr] if rd_ptr<len else 8'hFF; rd_ptr increments.
REQ-022 Pass SHALL end on tick performing shift number len+4; that cycle done_amisha pulses one clock.
REQ-023 start_amisha and wr_en_amisha in SCROLL SHALL be ignored.
REQ-024 stop_amisha in SCROLL SHALL return to IDLE next edge, blank digits, clear busy, no done pulse; stop wins over simultaneous tick.
REQ-025 Buffer contents and len SHALL be retained across passes and stop; start replays message.

Reset
REQ-026 On reset_amisha, without waiting for clock: state IDLE, len 0, counter 0, rd_ptr 0.
REQ-027 Reset values: in3..in0 = 8'hFF, busy 0, done 0, wr_ready 1.
REQ-028 Reset mid-scroll SHALL abort immediately with no done pulse.

Configuration
REQ-029 Macro SCROLL_LOOP_EN defined: at pass end done pulses, rd_ptr and counter restart, digits blanked, state stays SCROLL until stop.
REQ-030 SCROLL_LOOP_EN undefined: at pass end FSM returns to IDLE, busy falls same edge as done rises, digits left blank.

Verification (DVSR=4, DEPTH=8)
REQ-031 Reset asserted -> in3..in0=FF, busy 0, done 0, wr_ready 1, asynchronously.
REQ-032 Write C0,F9,A4,B0,99, start -> after 4th tick (16 clk) in3..in0=C0,F9,A4,B0; 5th tick F9,A4,B0,99; done at 9th tick (36 clk), busy 0, digits FF.
REQ-033 Write 9 bytes in IDLE -> wr_ready low after 8th, 9th dropped; pass length 12 ticks.
REQ-034 Start with empty buffer, and start+single write same cycle -> first ignored; second enters SCROLL, done after 5 ticks.
REQ-035 stop at tick 3 (simultaneous with tick) -> IDLE next clock, digits FF, no done; restart replays from first byte.
REQ-036 SCROLL_LOOP_EN, 5-byte message -> done every 36 clk, busy stays 1 until stop.
